uart_tx_controller: RTL and testbench



---
 rtl/uart_tx_controller.sv | 138 +++++++++++++
 tb/tb_uart_tx_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// UART transmitter: 8 data bits LSB first, 1 stop bit, one-byte holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_controller #(
  parameter int TX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Tx_Valid,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int            CW       = $clog2(TX_OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(TX_OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    hold_q;
  logic          full_q;
  logic          serial_q;
  logic          done_q;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
  assign accept  = i_Tx_Valid && !full_q;

  assign o_Tx_Ready  = ~full_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = (state_q != S_IDLE);
  assign o_Tx_Done   = done_q;

  // Accept and drain are mutually exclusive on full_q, so their writes never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      hold_q   <= 8'h00;
      full_q   <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_q <= i_Tx_Byte;
        full_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= 3'd0;
          if (full_q) begin
            shift_q  <= hold_q;
            full_q   <= 1'b0;
            state_q  <= S_START;
            serial_q <= 1'b0;
          end else begin
            serial_q <= 1'b1;
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q  <= S_DATA;
            idx_q    <= 3'd0;
            serial_q <= shift_q[0];
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= S_PARITY;
              serial_q <= ^shift_q;
`else
              state_q  <= S_STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              idx_q    <= idx_q + 3'd1;
              serial_q <= shift_q[idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q  <= S_STOP;
            serial_q <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            done_q <= 1'b1;
            if (full_q) begin
              shift_q  <= hold_q;
              full_q   <= 1'b0;
              state_q  <= S_START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= S_IDLE;
              serial_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed testbench for uart_tx_controller (oversample 16 and 2), follows UART_TX_PARITY_EN.
module tb_uart_tx_controller;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [10:0] P_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [10:0] P_00 = {1'b1, 1'b0, 8'h00, 1'b0};
  localparam logic [10:0] P_FF = {1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [10:0] P_07 = {1'b1, 1'b1, 8'h07, 1'b0};
  localparam logic [10:0] P_55 = {1'b1, 1'b0, 8'h55, 1'b0};
  localparam logic [10:0] P_81 = {1'b1, 1'b0, 8'h81, 1'b0};
`else
  localparam int          NB   = 10;
  localparam logic [10:0] P_A5 = {1'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [10:0] P_00 = {1'b0, 1'b1, 8'h00, 1'b0};
  localparam logic [10:0] P_FF = {1'b0, 1'b1, 8'hFF, 1'b0};
  localparam logic [10:0] P_07 = {1'b0, 1'b1, 8'h07, 1'b0};
  localparam logic [10:0] P_55 = {1'b0, 1'b1, 8'h55, 1'b0};
  localparam logic [10:0] P_81 = {1'b0, 1'b1, 8'h81, 1'b0};
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_Tx_Valid = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic       v2 = 1'b0;
  logic [7:0] b2 = 8'h00;
  logic       rdy2, ser2, act2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_controller #(.TX_OVERSAMPLE(OS)) u_dut (
    .clk(clk), .reset(reset), .i_Tx_Valid(i_Tx_Valid), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done)
  );

  uart_tx_controller #(.TX_OVERSAMPLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .i_Tx_Valid(v2), .i_Tx_Byte(b2),
    .o_Tx_Ready(rdy2), .o_Tx_Serial(ser2),
    .o_Tx_Active(act2), .o_Tx_Done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1 time unit after the accepting edge N.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_Tx_Valid = 1'b1;
    i_Tx_Byte  = b;
    @(posedge clk);
    #1;
    i_Tx_Valid = 1'b0;
  endtask

  // Starts sampling at the first start-bit cycle; returns at the cycle o_Tx_Done should be high.
  task automatic check_frame(input logic [10:0] pat, input logic exp_rdy, input string tag);
    logic bitv;
    for (int k = 0; k < NB * OS; k++) begin
      bitv = pat[k / OS];
      chk({tag, "_serial"}, {31'd0, o_Tx_Serial}, {31'd0, bitv});
      if (k == 0) chk({tag, "_active"}, {31'd0, o_Tx_Active}, 32'd1);
      if (k == 1 || k == 80) chk({tag, "_ready"}, {31'd0, o_Tx_Ready}, {31'd0, exp_rdy});
      if (k == NB * OS - 1) chk({tag, "_done_early"}, {31'd0, o_Tx_Done}, 32'd0);
      if (k == 1) i_Tx_Byte = 8'h3C;
      if (k == 100) i_Tx_Valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_serial", {31'd0, o_Tx_Serial}, 32'd1);
    chk("rst_ready",  {31'd0, o_Tx_Ready},  32'd1);
    chk("rst_active", {31'd0, o_Tx_Active}, 32'd0);
    chk("rst_done",   {31'd0, o_Tx_Done},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();

    // single byte 0xA5
    send_byte(8'hA5);
    chk("a5_ready_n", {31'd0, o_Tx_Ready}, 32'd0);
    tick();
    chk("a5_ready_n1", {31'd0, o_Tx_Ready}, 32'd1);
    check_frame(P_A5, 1'b1, "a5");
    chk("a5_done",   {31'd0, o_Tx_Done},   32'd1);
    chk("a5_active", {31'd0, o_Tx_Active}, 32'd0);
    chk("a5_idle",   {31'd0, o_Tx_Serial}, 32'd1);
    tick();
    chk("a5_done_off", {31'd0, o_Tx_Done}, 32'd0);
    tick();

    // back-to-back 0x00, 0xFF with valid held; 0x3C offered while full must be dropped
    @(negedge clk);
    i_Tx_Valid = 1'b1;
    i_Tx_Byte  = 8'h00;
    @(posedge clk);
    #1;
    chk("b2b_ready_n", {31'd0, o_Tx_Ready}, 32'd0);
    i_Tx_Byte = 8'hFF;
    tick();
    chk("b2b_ready_n1", {31'd0, o_Tx_Ready}, 32'd1);
    check_frame(P_00, 1'b0, "b2b_00");
    chk("b2b_done1",  {31'd0, o_Tx_Done},   32'd1);
    chk("b2b_nogap",  {31'd0, o_Tx_Serial}, 32'd0);
    chk("b2b_active", {31'd0, o_Tx_Active}, 32'd1);
    chk("b2b_ready2", {31'd0, o_Tx_Ready},  32'd1);
    check_frame(P_FF, 1'b1, "b2b_ff");
    chk("b2b_done2",   {31'd0, o_Tx_Done},   32'd1);
    chk("b2b_active2", {31'd0, o_Tx_Active}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_no3c_active", {31'd0, o_Tx_Active}, 32'd0);
    chk("b2b_no3c_serial", {31'd0, o_Tx_Serial}, 32'd1);

    // byte 0x07 (parity bit 1 when enabled)
    send_byte(8'h07);
    tick();
    check_frame(P_07, 1'b1, "b07");
    chk("b07_done",   {31'd0, o_Tx_Done},   32'd1);
    chk("b07_active", {31'd0, o_Tx_Active}, 32'd0);
    tick();

    // reset mid-frame with a byte queued
    send_byte(8'h55);
    tick();
    @(negedge clk);
    i_Tx_Valid = 1'b1;
    i_Tx_Byte  = 8'h99;
    @(posedge clk);
    #1;
    i_Tx_Valid = 1'b0;
    for (int i = 0; i < 48; i++) tick();
    chk("rst55_mid_serial", {31'd0, o_Tx_Serial}, {31'd0, P_55[3]});
    chk("rst55_mid_ready",  {31'd0, o_Tx_Ready},  32'd0);
    reset = 1'b1;
    #1;
    chk("rst55_serial", {31'd0, o_Tx_Serial}, 32'd1);
    chk("rst55_ready",  {31'd0, o_Tx_Ready},  32'd1);
    chk("rst55_active", {31'd0, o_Tx_Active}, 32'd0);
    chk("rst55_done",   {31'd0, o_Tx_Done},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst55_held_dropped", {31'd0, o_Tx_Active}, 32'd0);
    chk("rst55_no_done",      {31'd0, o_Tx_Done},   32'd0);
    send_byte(8'h81);
    tick();
    check_frame(P_81, 1'b1, "b81");
    chk("b81_done",   {31'd0, o_Tx_Done},   32'd1);
    chk("b81_active", {31'd0, o_Tx_Active}, 32'd0);
    tick();

    // oversample 2, byte 0xFF
    @(negedge clk);
    v2 = 1'b1;
    b2 = 8'hFF;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("os2_ready_n", {31'd0, rdy2}, 32'd0);
    tick();
    for (int k = 0; k < NB * 2; k++) begin
      chk("os2_serial", {31'd0, ser2}, {31'd0, P_FF[k / 2]});
      if (k == NB * 2 - 1) chk("os2_done_early", {31'd0, done2}, 32'd0);
      tick();
    end
    chk("os2_done",   {31'd0, done2}, 32'd1);
    chk("os2_active", {31'd0, act2},  32'd0);
    tick();
    chk("os2_done_off", {31'd0, done2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
